// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter that time-shares one radix-4 Booth multiplier among NREQ
// requesters; each product is held in a response register until accepted.

module booth_mul_arbiter #(
  parameter int unsigned N          = 16,
  parameter int unsigned NREQ       = 4,
  parameter int unsigned LSB_APPROX = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*N-1:0]       req_a,
  input  logic [NREQ*N-1:0]       req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2*N-1:0]          rsp_data,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    busy,
  output logic [15:0]             op_count
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned PW = 2 * N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e        state_q;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] id_q, rsp_id_q;
  logic [IW-1:0] gnt_idx, cand;
  logic          gnt_found;
  logic [N-1:0]  op_a_q, op_b_q;
  logic [N-1:0]  a_arr [NREQ];
  logic [N-1:0]  b_arr [NREQ];
  logic [PW-1:0] prod, rsp_data_q;
  logic          rsp_valid_q;
  logic [15:0]   op_count_q, op_count_d;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*N +: N];
    assign b_arr[g] = req_b[g*N +: N];
  end

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(rr_ptr_q) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
    rr_ptr_d   = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
    op_count_d = op_count_q + 16'd1;
  end

  booth #(
    .N   (N),
    .lsb (LSB_APPROX)
  ) u_booth (
    .a_i   (op_a_q),
    .b_i   (op_b_q),
    .res_o (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            op_a_q   <= a_arr[gnt_idx];
            op_b_q   <= b_arr[gnt_idx];
            id_q     <= gnt_idx;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= MUL;
          end
        end
        MUL: begin
          rsp_data_q  <= prod;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_d;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q != IDLE);

endmodule

// Combinational radix-4 Booth multiplier; partial-product columns below lsb
// are dropped, so lsb = 0 yields the exact signed product.
module booth #(
  parameter int unsigned N   = 16,
  parameter int unsigned lsb = 0
) (
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] res_o
);

  localparam int unsigned   PW       = 2 * N;
  localparam int unsigned   NPP      = N / 2;
  localparam logic [PW-1:0] LOW_MASK = ~({PW{1'b1}} << lsb);

  logic [N:0]    b_ext;
  logic [PW-1:0] a_sx;
  logic [PW-1:0] pp, acc;
  logic [2:0]    digit;

  assign b_ext = {b_i, 1'b0};
  assign a_sx  = {{N{a_i[N-1]}}, a_i};

  always_comb begin
    acc   = '0;
    pp    = '0;
    digit = '0;
    for (int unsigned j = 0; j < NPP; j++) begin
      digit = b_ext[2*j +: 3];
      case (digit)
        3'b001, 3'b010: pp = a_sx;
        3'b011:         pp = a_sx << 1;
        3'b100:         pp = -(a_sx << 1);
        3'b101, 3'b110: pp = -a_sx;
        default:        pp = '0;
      endcase
      pp  = (pp << (2 * j)) & ~LOW_MASK;
      acc = acc + pp;
    end
  end

  assign res_o = acc;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed and randomized checks of booth_mul_arbiter against a behavioural
// round-robin / signed-product reference.

module tb_booth_mul_arbiter;

  localparam int unsigned N     = 16;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned IW    = 2;
  localparam int unsigned NRAND = 10000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [2*N-1:0]    rsp_data;
  logic [IW-1:0]     rsp_id;
  logic              busy;
  logic [15:0]       op_count;

  int          checks = 0;
  int          errors = 0;
  logic [N-1:0] ma [NREQ];
  logic [N-1:0] mb [NREQ];
  logic [15:0] ops_m;

  int          gcyc [5];
  int          gidx [5];
  int          ng, cyc, nreq, nrsp, ptr_m, pend_id, pend_cyc, g;
  bit          outstanding;
  bit          hs [NREQ];
  logic [31:0] pend_p, bp_data;
  logic [NREQ-1:0] exp_rdy;

  booth_mul_arbiter #(
    .N          (16),
    .NREQ       (4),
    .LSB_APPROX (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 32'(sa * sb);
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[IW'(i)]) return i;
    return -1;
  endfunction

  task automatic pack();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = ma[IW'(i)];
      req_b[i*N +: N] = mb[IW'(i)];
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ops_m = '0;
  endtask

  task automatic wait_grant(input logic [IW-1:0] idx, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready[idx] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(req_ready), 64'd1 << idx);
  endtask

  // Called just after the handshake edge; expects MUL, then RESP, then accept.
  task automatic finish_op(input logic [IW-1:0] idx, input logic [31:0] expd, input string tag);
    @(negedge clk);
    chk({tag, "_mul_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_data"}, 64'(rsp_data), 64'(expd));
    chk({tag, "_id"}, 64'(rsp_id), 64'(idx));
    ops_m++;
    @(negedge clk);
    chk({tag, "_drop"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_opcnt"}, 64'(op_count), 64'(ops_m));
  endtask

  task automatic do_op(input logic [IW-1:0] idx, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] expd, input string tag);
    @(posedge clk); #1;
    ma[idx] = a;
    mb[idx] = b;
    pack();
    rsp_ready      = 1'b1;
    req_valid[idx] = 1'b1;
    wait_grant(idx, {tag, "_grant"});
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    finish_op(idx, expd, tag);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    ops_m     = '0;
    for (int i = 0; i < NREQ; i++) begin
      ma[IW'(i)] = '0;
      mb[IW'(i)] = '0;
    end
    do_reset();

    // Single requests, signed corner operands
    do_op(2'd1, 16'h0003, 16'h0005, 32'h0000000F, "single");
    do_op(2'd0, 16'hFFFF, 16'h0002, 32'hFFFFFFFE, "neg_one");
    do_op(2'd3, 16'h7FFF, 16'h7FFF, 32'h3FFF0001, "max_pos");
    do_op(2'd2, 16'h8000, 16'h8000, 32'h40000000, "min_neg");
    do_op(2'd1, 16'h8000, 16'h7FFF, 32'hC0008000, "min_max");

    // Fairness: all requesters held valid from a fresh reset
    do_reset();
    @(negedge clk);
    chk("fair_opcnt0", 64'(op_count), 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = '1;
    ng  = 0;
    cyc = 0;
    while (ng < 5 && cyc < 40) begin
      @(negedge clk);
      if (req_ready != '0) begin
        gidx[ng] = onehot_idx(req_ready);
        gcyc[ng] = cyc;
        ng++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    req_valid = '0;
    chk("fair_grants", 64'(ng), 64'd5);
    for (int k = 0; k < ng; k++) begin
      chk("fair_order", 64'(gidx[k]), 64'(k % NREQ));
      if (k > 0) chk("fair_spacing", 64'(gcyc[k] - gcyc[k-1]), 64'd3);
    end
    repeat (3) @(negedge clk);
    ops_m = 16'd5;
    chk("fair_opcnt", 64'(op_count), 64'(ops_m));

    // Backpressure with a competing request held off
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    ma[2] = 16'h1234; mb[2] = 16'hFEDC;
    ma[0] = 16'h0010; mb[0] = 16'h0010;
    pack();
    req_valid = 4'b0101;
    wait_grant(2'd2, "bp_grant");
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid", 64'(rsp_valid), 64'd1);
    bp_data = 32'hFFEB3CB0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_data", 64'(rsp_data), 64'(bp_data));
      chk("bp_id", 64'(rsp_id), 64'd2);
      chk("bp_ready_low", 64'(req_ready), 64'd0);
      chk("bp_opcnt_hold", 64'(op_count), 64'(ops_m));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    ops_m++;
    @(negedge clk);
    chk("bp_opcnt_inc", 64'(op_count), 64'(ops_m));
    chk("bp_held_req", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    finish_op(2'd0, 32'h00000100, "bp_next");

    // Reset while the multiplier cycle is in flight
    @(posedge clk); #1;
    ma[3] = 16'h0005; mb[3] = 16'h0007;
    ma[1] = 16'h0002; mb[1] = 16'hFFFD;
    pack();
    req_valid = 4'b1000;
    wait_grant(2'd3, "rm_grant");
    @(posedge clk); #1;
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("rm_valid", 64'(rsp_valid), 64'd0);
    chk("rm_busy", 64'(busy), 64'd0);
    chk("rm_opcnt", 64'(op_count), 64'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    ops_m     = '0;
    req_valid = 4'b0110;
    @(negedge clk);
    chk("rm_lowest_grant", 64'(req_ready), 64'b0010);
    chk("rm_valid_after", 64'(rsp_valid), 64'd0);
    chk("rm_opcnt_after", 64'(op_count), 64'd0);
    @(posedge clk); #1;
    req_valid = '0;
    finish_op(2'd1, 32'hFFFFFFFA, "rm_next");

    // Randomized traffic against the reference model
    do_reset();
    ptr_m       = 0;
    outstanding = 1'b0;
    pend_id     = 0;
    pend_cyc    = 0;
    pend_p      = '0;
    nreq        = 0;
    nrsp        = 0;
    cyc         = 0;
    for (int i = 0; i < NREQ; i++) hs[i] = 1'b0;
    while ((nreq < NRAND || outstanding) && cyc < 60000) begin
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (nreq >= NRAND) begin
          req_valid[IW'(i)] = 1'b0;
        end else if (hs[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            ma[IW'(i)] = rnd16();
            mb[IW'(i)] = rnd16();
          end else begin
            req_valid[IW'(i)] = 1'b0;
          end
        end else if (!req_valid[IW'(i)]) begin
          if ($urandom_range(0, 1) == 1) begin
            req_valid[IW'(i)] = 1'b1;
            ma[IW'(i)] = rnd16();
            mb[IW'(i)] = rnd16();
          end
        end else if ($urandom_range(0, 31) == 0) begin
          req_valid[IW'(i)] = 1'b0;
        end
        hs[i] = 1'b0;
      end
      pack();
      @(negedge clk);
      cyc++;
      chk("rand_opcnt", 64'(op_count), 64'(ops_m));
      exp_rdy = '0;
      g = -1;
      if (!outstanding) begin
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && req_valid[IW'((ptr_m + k) % NREQ)]) g = (ptr_m + k) % NREQ;
        end
        if (g >= 0) exp_rdy = NREQ'(1) << g;
      end
      chk("rand_ready", 64'(req_ready), 64'(exp_rdy));
      chk("rand_rsp_valid", 64'(rsp_valid), 64'(outstanding && (cyc - pend_cyc >= 2)));
      if (rsp_valid && rsp_ready && outstanding) begin
        chk("rand_rsp_id", 64'(rsp_id), 64'(pend_id));
        chk("rand_rsp_data", 64'(rsp_data), 64'(pend_p));
        outstanding = 1'b0;
        ops_m++;
        nrsp++;
      end
      if (g >= 0) begin
        outstanding = 1'b1;
        pend_id     = g;
        pend_p      = prod(ma[IW'(g)], mb[IW'(g)]);
        pend_cyc    = cyc;
        ptr_m       = (g + 1) % NREQ;
        hs[g]       = 1'b1;
        nreq++;
      end
    end
    chk("rand_req_count", 64'(nreq), 64'(NRAND));
    chk("rand_rsp_count", 64'(nrsp), 64'(NRAND));
    chk("rand_drained", 64'(outstanding), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
